// File: rtl/instruction_fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
// Holds the fetch FSM state encoding and the word-offset helper.
package instruction_fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int OFF_W   = 8;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Signed word offset -> signed byte offset at full PC width
    function automatic logic [PC_W-1:0] word_off_to_bytes(
        input logic [OFF_W-1:0] off
    );
        return {{(PC_W-OFF_W-2){off[OFF_W-1]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of instruction-memory and decode-side signals of the fetch unit.
// master = fetch unit, slave = memory/decode environment.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic               imem_read;
    logic [PC_W-1:0]    imem_address;
    logic [INSTR_W-1:0] imem_readdata;
    logic               imem_busywait;

    logic               stall;
    logic               redirect;
    logic [OFF_W-1:0]   offset;

    logic [INSTR_W-1:0] instruction;
    logic               inst_valid;
    logic [PC_W-1:0]    inst_pc;

    modport master (
        output imem_read,
        output imem_address,
        input  imem_readdata,
        input  imem_busywait,
        input  stall,
        input  redirect,
        input  offset,
        output instruction,
        output inst_valid,
        output inst_pc
    );

    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_readdata,
        output imem_busywait,
        output stall,
        output redirect,
        output offset,
        input  instruction,
        input  inst_valid,
        input  inst_pc
    );

endinterface

// File: rtl/instruction_fetch_target_adder.sv
// Redirect target and sequential next-fetch address computation.
// Both wrap modulo 2^32.
module fetch_target_adder
    import instruction_fetch_pkg::*;
(
    input  logic [PC_W-1:0]  inst_pc_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [PC_W-1:0]  fetch_addr_i,
    output logic [PC_W-1:0]  target_o,
    output logic [PC_W-1:0]  pc_inc_o
);

    assign target_o = inst_pc_i + PC_W'(4) + word_off_to_bytes(offset_i);
    assign pc_inc_o = fetch_addr_i + PC_W'(4);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: single outstanding memory read, one-entry skid
// buffer for decode back-pressure, and redirect with in-flight drain.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic               clk_i,
    input logic               reset_ni,
    instruction_fetch_if.master bus
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    fetch_addr_q, fetch_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    inst_pc_q, inst_pc_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] skid_word_q, skid_word_d;
    logic [PC_W-1:0]    skid_addr_q, skid_addr_d;
    logic               skid_valid_q, skid_valid_d;

    logic               imem_read;
    logic               consume;
    logic               redir;
    logic [PC_W-1:0]    target;
    logic [PC_W-1:0]    pc_inc;

    assign consume = valid_q & ~bus.stall;
    assign redir   = consume & bus.redirect;

    fetch_target_adder u_target (
        .inst_pc_i    (inst_pc_q),
        .offset_i     (bus.offset),
        .fetch_addr_i (fetch_addr_q),
        .target_o     (target),
        .pc_inc_o     (pc_inc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        instr_d      = instr_q;
        inst_pc_d    = inst_pc_q;
        valid_d      = valid_q;
        skid_word_d  = skid_word_q;
        skid_addr_d  = skid_addr_q;
        skid_valid_d = skid_valid_q;
        imem_read    = 1'b0;

        unique case (state_q)
            FETCH: begin
                imem_read = 1'b1;
                if (redir) begin
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    pc_d         = target;
                    // A busy request must finish before the target is issued
                    if (bus.imem_busywait) begin
                        state_d = DRAIN;
                    end else begin
                        fetch_addr_d = target;
                    end
                end else if (!bus.imem_busywait) begin
                    if (!valid_q || consume) begin
                        instr_d      = bus.imem_readdata;
                        inst_pc_d    = fetch_addr_q;
                        valid_d      = 1'b1;
                        pc_d         = pc_inc;
                        fetch_addr_d = pc_inc;
                    end else begin
                        skid_word_d  = bus.imem_readdata;
                        skid_addr_d  = fetch_addr_q;
                        skid_valid_d = 1'b1;
                        pc_d         = pc_inc;
                        state_d      = FULL;
                    end
                end else if (consume) begin
                    valid_d = 1'b0;
                end
            end

            FULL: begin
                if (redir) begin
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    pc_d         = target;
                    fetch_addr_d = target;
                    state_d      = FETCH;
                end else if (consume) begin
                    instr_d      = skid_word_q;
                    inst_pc_d    = skid_addr_q;
                    valid_d      = skid_valid_q;
                    skid_valid_d = 1'b0;
                    fetch_addr_d = pc_q;
                    state_d      = FETCH;
                end
            end

            DRAIN: begin
                imem_read = 1'b1;
                valid_d   = 1'b0;
                if (!bus.imem_busywait) begin
                    fetch_addr_d = pc_q;
                    state_d      = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            instr_q      <= '0;
            inst_pc_q    <= '0;
            valid_q      <= 1'b0;
            skid_word_q  <= '0;
            skid_addr_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            instr_q      <= instr_d;
            inst_pc_q    <= inst_pc_d;
            valid_q      <= valid_d;
            skid_word_q  <= skid_word_d;
            skid_addr_q  <= skid_addr_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.imem_read    = imem_read;
    assign bus.imem_address = fetch_addr_q;
    assign bus.instruction  = instr_q;
    assign bus.inst_valid   = valid_q;
    assign bus.inst_pc      = inst_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, corner sequences,
// and randomized traffic against a program-order reference model.
module tb_instruction_fetch;

    logic clk;
    logic reset_n;
    logic busy;
    int   tests;
    int   failed;

    instruction_fetch_if bus ();

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign bus.imem_readdata = mem_word(bus.imem_address);
    assign bus.imem_busywait = busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [7:0]  offset;
        logic        busy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_read;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r,
                         input logic [7:0] o, input logic b);
        bus.stall    = s;
        bus.redirect = r;
        bus.offset   = o;
        busy         = b;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic add(input logic s, input logic r, input logic [7:0] o,
                       input logic b, input logic ev, input logic [31:0] ep,
                       input logic er, input logic [31:0] ea);
        vec_t v;
        v.stall = s; v.redirect = r; v.offset = o; v.busy = b;
        v.e_valid = ev; v.e_pc = ep; v.e_read = er; v.e_addr = ea;
        vq.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        prev_hold;
        logic        prev_redir;
        logic [7:0]  off_r;
        int          cnt;
        int          consumes;
        int          off_i;

        tests  = 0;
        failed = 0;
        busy   = 1'b0;

        // stall, redirect, offset, busy | valid, inst_pc, read, address
        add(0, 0, 8'h00, 0, 1, 32'd0,  1, 32'd4);
        add(0, 0, 8'h00, 0, 1, 32'd4,  1, 32'd8);
        add(1, 0, 8'h00, 0, 1, 32'd4,  0, 32'd8);
        add(1, 0, 8'h00, 0, 1, 32'd4,  0, 32'd8);
        add(1, 0, 8'h00, 0, 1, 32'd4,  0, 32'd8);
        add(1, 1, 8'h05, 0, 1, 32'd4,  0, 32'd8);
        add(1, 0, 8'h00, 1, 1, 32'd4,  0, 32'd8);
        add(0, 0, 8'h00, 0, 1, 32'd8,  1, 32'd12);
        add(0, 0, 8'h00, 1, 0, 32'd8,  1, 32'd12);
        add(0, 0, 8'h00, 0, 1, 32'd12, 1, 32'd16);
        add(0, 0, 8'h00, 0, 1, 32'd16, 1, 32'd20);
        add(0, 1, 8'hFE, 0, 0, 32'd16, 1, 32'd12);
        add(0, 0, 8'h00, 0, 1, 32'd12, 1, 32'd16);
        add(0, 1, 8'h02, 1, 0, 32'd12, 1, 32'd16);
        add(0, 1, 8'h02, 1, 0, 32'd12, 1, 32'd16);
        add(0, 0, 8'h00, 0, 0, 32'd12, 1, 32'd24);
        add(0, 0, 8'h00, 0, 1, 32'd24, 1, 32'd28);
        add(1, 0, 8'h00, 1, 1, 32'd24, 1, 32'd28);
        add(1, 1, 8'h80, 0, 1, 32'd24, 0, 32'd28);
        add(0, 0, 8'h00, 0, 1, 32'd28, 1, 32'd32);

        do_reset();
        check("reset valid", 32'(bus.inst_valid), 32'd0);
        check("reset read", 32'(bus.imem_read), 32'd1);
        check("reset addr", bus.imem_address, 32'h0);
        check("reset instr", bus.instruction, 32'h0);
        check("reset inst_pc", bus.inst_pc, 32'h0);

        foreach (vq[i]) begin
            drive(vq[i].stall, vq[i].redirect, vq[i].offset, vq[i].busy);
            tick();
            check($sformatf("vec%0d valid", i), 32'(bus.inst_valid),
                  32'(vq[i].e_valid));
            check($sformatf("vec%0d inst_pc", i), bus.inst_pc, vq[i].e_pc);
            check($sformatf("vec%0d instr", i), bus.instruction,
                  mem_word(vq[i].e_pc));
            check($sformatf("vec%0d read", i), 32'(bus.imem_read),
                  32'(vq[i].e_read));
            check($sformatf("vec%0d addr", i), bus.imem_address,
                  vq[i].e_addr);
        end

        // Three busy cycles per fetch: address held for four cycles
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 4; c++) begin
                drive(1'b0, 1'b0, 8'h00, c < 3);
                tick();
                if (c < 3) begin
                    check($sformatf("bw f%0d c%0d addr", f, c),
                          bus.imem_address, 32'(4 * f));
                    check($sformatf("bw f%0d c%0d read", f, c),
                          32'(bus.imem_read), 32'd1);
                end else begin
                    check($sformatf("bw f%0d addr", f),
                          bus.imem_address, 32'(4 * (f + 1)));
                    check($sformatf("bw f%0d valid", f),
                          32'(bus.inst_valid), 32'd1);
                    check($sformatf("bw f%0d inst_pc", f),
                          bus.inst_pc, 32'(4 * f));
                end
            end
        end

        // Backward redirect from 0 wraps to the top of the address space
        do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'hFE, 1'b0);
        tick();
        check("wrap redir valid", 32'(bus.inst_valid), 32'd0);
        check("wrap redir addr", bus.imem_address, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        check("wrap inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
        check("wrap instr", bus.instruction, mem_word(32'hFFFF_FFFC));
        check("wrap next addr", bus.imem_address, 32'h0);
        tick();
        check("wrap after inst_pc", bus.inst_pc, 32'h0);

        // Reset while FULL
        do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        check("full entered read", 32'(bus.imem_read), 32'd0);
        reset_n = 1'b0;
        tick();
        check("rst full addr", bus.imem_address, 32'h0);
        check("rst full valid", 32'(bus.inst_valid), 32'd0);
        check("rst full read", 32'(bus.imem_read), 32'd1);
        reset_n = 1'b1;

        // Reset while DRAIN
        do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'h10, 1'b1);
        tick();
        check("drain addr", bus.imem_address, 32'd4);
        check("drain valid", 32'(bus.inst_valid), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        reset_n = 1'b0;
        tick();
        check("rst drain addr", bus.imem_address, 32'h0);
        check("rst drain valid", 32'(bus.inst_valid), 32'd0);
        reset_n = 1'b1;

        // Randomized traffic against a program-order model
        do_reset();
        exp_pc     = 32'h0;
        cnt        = 0;
        consumes   = 0;
        prev_hold  = 1'b0;
        prev_redir = 1'b0;
        prev_addr  = 32'h0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (prev_hold) begin
                check("rnd hold read", 32'(bus.imem_read), 32'd1);
                check("rnd hold addr", bus.imem_address, prev_addr);
            end
            if (prev_redir) begin
                check("rnd redir valid", 32'(bus.inst_valid), 32'd0);
            end
            bus.stall = ($urandom_range(0, 3) == 0);
            if (bus.imem_read) begin
                if (cnt > 0) begin
                    busy = 1'b1;
                    cnt--;
                end else begin
                    busy = 1'b0;
                    cnt  = $urandom_range(0, 3);
                end
            end else begin
                busy = 1'b0;
            end
            off_r        = 8'($urandom);
            bus.offset   = off_r;
            bus.redirect = ($urandom_range(0, 5) == 0);
            prev_hold    = bus.imem_read && busy;
            prev_addr    = bus.imem_address;
            prev_redir   = 1'b0;
            if (bus.inst_valid && !bus.stall) begin
                check("rnd inst_pc", bus.inst_pc, exp_pc);
                check("rnd instr", bus.instruction, mem_word(exp_pc));
                consumes++;
                if (bus.redirect) begin
                    off_i      = int'($signed(off_r));
                    exp_pc     = exp_pc + 32'd4 + 32'(off_i * 4);
                    prev_redir = 1'b1;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
            tick();
        end
        check("rnd progress", 32'(consumes >= 400), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
